// File: rtl/separador_numeros.sv
// Binary-to-decimal ASCII streamer: double-dabble conversion, then sends the significant digits
// most significant first over a tx_start / tx_done byte handshake.
module separador_numeros #(
  parameter int unsigned DataW     = 32,
  parameter int unsigned NumDigits = 10,
  parameter logic [7:0]  AsciiBase = 8'h30
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [DataW-1:0] alu_in_i,
  input  logic             start_conversion_i,
  input  logic             tx_done_i,
  output logic [7:0]       value_to_send_o,
  output logic             tx_start_o
);

  localparam int unsigned BcdW = 4 * NumDigits;
  localparam int unsigned IdxW = $clog2(NumDigits);
  localparam int unsigned CntW = $clog2(DataW + 1);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StFind,
    StSend,
    StWaitLow,
    StWaitHigh
  } state_e;

  state_e            state_q;
  logic [DataW-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q, msd_idx;
  logic [3:0]        digit;
  logic [7:0]        value_q;
  logic              tx_start_q;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
    {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
  end

  // Highest non-zero digit; stays at the units digit for a zero value.
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd_idx = IdxW'(i);
    end
  end

  always_comb begin
    digit = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (idx_q == IdxW'(i)) digit = bcd_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      value_q    <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_conversion_i) begin
            bin_q   <= alu_in_i;
            bcd_q   <= '0;
            cnt_q   <= CntW'(DataW);
            state_q <= StConvert;
          end
        end
        StConvert: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StFind;
        end
        StFind: begin
          idx_q   <= msd_idx;
          state_q <= StSend;
        end
        StSend: begin
          if (tx_done_i) begin
            value_q    <= AsciiBase + {4'b0000, digit};
            tx_start_q <= 1'b1;
            state_q    <= StWaitLow;
          end
        end
        StWaitLow: begin
          if (!tx_done_i) state_q <= StWaitHigh;
        end
        StWaitHigh: begin
          if (tx_done_i) begin
            if (idx_q == '0) begin
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q - IdxW'(1);
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign value_to_send_o = value_q;
  assign tx_start_o      = tx_start_q;

endmodule

// File: tb/tb_separador_numeros.sv
// Directed bench for separador_numeros with a UART model that holds tx_done low 15 cycles per byte.
module tb_separador_numeros;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_in = '0;
  logic        start = 1'b0;
  logic        tx_done = 1'b1;
  logic [7:0]  value;
  logic        tx_start;

  int          errs = 0;
  int          checks = 0;
  int          ncyc = 0;
  int          busy = 0;
  int          b2b = 0;
  int          s_cyc = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  pulses[$];
  int          pulse_cyc[$];

  separador_numeros dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .alu_in_i          (alu_in),
    .start_conversion_i(start),
    .tx_done_i         (tx_done),
    .value_to_send_o   (value),
    .tx_start_o        (tx_start)
  );

  always #5 clk = ~clk;

  // Pulse monitor and UART model, both evaluated mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    if (tx_start) begin
      pulses.push_back(value);
      pulse_cyc.push_back(ncyc);
      if (prev_start) b2b++;
      busy    = 15;
      tx_done = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) tx_done = 1'b1;
    end
    prev_start = tx_start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pulses.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_pulses", pulses.size(), n);
  endtask

  // Pulse start for one cycle; s_cyc is the negedge index that follows the accepting edge.
  task automatic kick(input logic [31:0] v);
    pulses.delete();
    pulse_cyc.delete();
    @(negedge clk);
    #1;
    alu_in = v;
    start  = 1'b1;
    s_cyc  = ncyc + 1;
    @(negedge clk);
    #1;
    start  = 1'b0;
    alu_in = $urandom;
  endtask

  task automatic run_case(input string tag, input logic [31:0] v, input string exp);
    kick(v);
    wait_pulses(exp.len(), 1000);
    repeat (60) @(negedge clk);
    #1;
    check({tag, "_count"}, pulses.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (i < pulses.size()) check($sformatf("%s_d%0d", tag, i), {24'h0, pulses[i]}, {24'h0, exp[i]});
    end
    if (pulse_cyc.size() > 0) check({tag, "_latency"}, pulse_cyc[0] - s_cyc, 34);
    check({tag, "_hold"}, {24'h0, value}, {24'h0, exp[exp.len()-1]});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_start", {31'h0, tx_start}, 0);
    check("rst_value", {24'h0, value}, 0);
    reset = 1'b0;

    run_case("big", 32'd1234567898, "1234567898");
    run_case("two", 32'd43, "43");
    run_case("zero", 32'd0, "0");
    run_case("max", 32'hFFFF_FFFF, "4294967295");

    // Start request during the second digit must be ignored.
    kick(32'd43);
    wait_pulses(2, 200);
    @(negedge clk);
    #1;
    alu_in = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    #1;
    start  = 1'b0;
    repeat (120) @(negedge clk);
    #1;
    check("ign_count", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      check("ign_d0", {24'h0, pulses[0]}, 32'h34);
      check("ign_d1", {24'h0, pulses[1]}, 32'h33);
    end

    // Reset while waiting for the first byte to finish.
    kick(32'd1234567898);
    wait_pulses(1, 200);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_tx_start", {31'h0, tx_start}, 0);
    check("abort_value", {24'h0, value}, 0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    check("abort_no_more", pulses.size(), 1);

    run_case("after_rst", 32'd7, "7");
    check("no_back_to_back", b2b, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
